// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Parity support is built only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int MIN_DIV   = 4;
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty/level status.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronizer, mid-bit sampling FSM, byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    parameter  int DIV_W      = 16,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             uart_rx,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             err_clr,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] fifo_level,
    output logic             frame_err,
    output logic             overrun,
    output logic             irq
`ifdef UART_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    localparam int BIT_W = $clog2(DATA_BITS);

    rx_state_e              state, state_d;
    logic [DIV_W-1:0]       cnt, cnt_d;
    logic [BIT_W-1:0]       bit_idx, bit_d;
    logic [DATA_BITS-1:0]   shift, shift_d;
    logic [DIV_W-1:0]       full_div;
    logic                   sync1, rx_s, rx_d;
    logic                   fall, expired;
    logic                   push, frame_set, pop, fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic                   parity_set;
`endif

    // Line idles high, so the synchronizer resets to 1 to avoid a phantom start edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
        end
    end

    assign fall     = rx_d && !rx_s;
    assign expired  = (cnt == '0);
    assign full_div = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shift   <= shift_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state;
        cnt_d     = expired ? cnt : cnt - 1'b1;
        bit_d     = bit_idx;
        shift_d   = shift;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_set = 1'b0;
`endif
        // Reload with divisor-1 so one bit spans exactly full_div clocks.
        case (state)
            IDLE: begin
                if (rx_en && fall) begin
                    state_d = START;
                    cnt_d   = full_div >> 1;
                end
            end
            START: begin
                if (expired) begin
                    if (!rx_s) begin
                        state_d = DATA;
                        cnt_d   = full_div - 1'b1;
                        bit_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_d = {rx_s, shift[DATA_BITS-1:1]};
                    cnt_d   = full_div - 1'b1;
                    if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expired) begin
                    parity_set = (rx_s != ^shift);
                    cnt_d      = full_div - 1'b1;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (expired) begin
                    push      = rx_s;
                    frame_set = !rx_s;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rx_en) begin
            state_d   = IDLE;
            push      = 1'b0;
            frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_set = 1'b0;
`endif
        end
    end

    assign pop      = rd_valid && rd_ready;
    assign rd_valid = !fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shift),
        .pop       (pop),
        .pop_data  (rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A set event in the same cycle as err_clr keeps the flag high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set)                    frame_err <= 1'b1;
            else if (err_clr)                 frame_err <= 1'b0;
            if (push && fifo_full && !pop)    overrun   <= 1'b1;
            else if (err_clr)                 overrun   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         parity_err <= 1'b0;
        else if (parity_set) parity_err <= 1'b1;
        else if (err_clr)    parity_err <= 1'b0;
    end

    assign irq = rd_valid | frame_err | overrun | parity_err;
`else
    assign irq = rd_valid | frame_err | overrun;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at baud_div=16, FIFO_DEPTH=4.
// Frames are driven on the falling clock edge; outputs are sampled there too.
module tb_uart_rx_deframer;

    localparam int DEPTH = 4;
    localparam int DIV   = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic             uart_rx;
    logic             rx_en;
    logic [15:0]      baud_div;
    logic             err_clr;
    logic             rd_valid;
    logic [7:0]       rd_data;
    logic             rd_ready;
    logic [CNT_W-1:0] fifo_level;
    logic             frame_err;
    logic             overrun;
    logic             irq;
`ifdef UART_RX_PARITY_EN
    logic             parity_err;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_rx_deframer #(
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .uart_rx    (uart_rx),
        .rx_en      (rx_en),
        .baud_div   (baud_div),
        .err_clr    (err_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .irq        (irq)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        uart_rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d, input logic par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PB == 1) drive_bit(par_ok ? ^d : ~^d);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        send_head(d, par_ok);
        drive_bit(stop);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        resetn   = 1'b0;
        uart_rx  = 1'b1;
        rx_en    = 1'b1;
        baud_div = 16'(DIV);
        err_clr  = 1'b0;
        rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5: stop sample lands 11 clocks after the stop bit starts, visible one clock later.
        send_head(8'hA5, 1'b1);
        uart_rx = 1'b1;
        repeat (11) @(negedge clk);
        chk("a5_before", 32'(rd_valid), 32'd0);
        @(negedge clk);
        chk("a5_after", 32'(rd_valid), 32'd1);
        repeat (4) @(negedge clk);
        chk("a5_level", 32'(fifo_level), 32'd1);
        chk("a5_ferr", 32'(frame_err), 32'd0);
        chk("a5_ovr", 32'(overrun), 32'd0);
        chk("a5_irq", 32'(irq), 32'd1);
        pop_check("a5_pop", 8'hA5);
        chk("a5_empty", 32'(rd_valid), 32'd0);

        // 0x3C with a low stop bit is dropped and flagged.
        send_frame(8'h3C, 1'b0, 1'b1);
        chk("fe_flag", 32'(frame_err), 32'd1);
        chk("fe_irq", 32'(irq), 32'd1);
        chk("fe_valid", 32'(rd_valid), 32'd0);
        clear_errors();
        chk("fe_clr", 32'(frame_err), 32'd0);
        chk("fe_clr_irq", 32'(irq), 32'd0);

        // Three-clock low glitch must be rejected as a false start.
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("gl_level", 32'(fifo_level), 32'd0);
        chk("gl_ferr", 32'(frame_err), 32'd0);
        chk("gl_irq", 32'(irq), 32'd0);

        // Disable mid-frame during 0x55, then a clean 0x81.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_en = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (150) @(negedge clk);
        chk("en_level", 32'(fifo_level), 32'd0);
        chk("en_ferr", 32'(frame_err), 32'd0);
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1);
        chk("en_level2", 32'(fifo_level), 32'd1);
        pop_check("en_pop", 8'h81);

        // Five bytes into a four-entry FIFO with no reads.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b1);
        chk("ov_level", 32'(fifo_level), 32'd4);
        chk("ov_flag", 32'(overrun), 32'd1);
        chk("ov_ferr", 32'(frame_err), 32'd0);
        repeat (10) @(negedge clk);
        chk("ov_hold", 32'(rd_data), 32'h01);
        pop_check("ov_pop1", 8'h01);
        pop_check("ov_pop2", 8'h02);
        pop_check("ov_pop3", 8'h03);
        pop_check("ov_pop4", 8'h04);
        chk("ov_empty", 32'(rd_valid), 32'd0);
        chk("ov_irq", 32'(irq), 32'd1);
        clear_errors();
        chk("ov_clr", 32'(overrun), 32'd0);
        chk("ov_clr_irq", 32'(irq), 32'd0);

`ifdef UART_RX_PARITY_EN
        chk("pe_idle", 32'(parity_err), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0);
        chk("pe_flag", 32'(parity_err), 32'd1);
        chk("pe_level", 32'(fifo_level), 32'd1);
        pop_check("pe_pop", 8'h07);
        clear_errors();
        chk("pe_clr", 32'(parity_err), 32'd0);
        chk("pe_irq", 32'(irq), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
